// File: rtl/alu_exec_unit.sv
// MIPS execute stage: ALU-control decode, 32-bit ALU with zero flag, and jump-index sign extension.
// Outputs are registered one cycle after the operands arrive. Define ALU_OVERFLOW_DETECT_EN to register signed add/sub overflow.
module alu_exec_unit #(
    parameter int WIDTH  = 32,
    parameter int JIDX_W = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [JIDX_W-1:0] jidx,
    output logic [3:0]        alu_ctrl,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic [WIDTH-1:0]  jext,
    output logic              out_valid,
    output logic              overflow
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;
    localparam logic [3:0] CTRL_XOR = 4'b1101;
    localparam logic [3:0] CTRL_BAD = 4'b1111;

    logic [3:0]       w_alu_ctrl;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_ovf;
    logic [WIDTH-1:0] w_jext;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [WIDTH-1:0] r_jext;
    logic             r_out_valid;
    logic             r_overflow;

    // ALU-control decode from main-control ALUOp and the R-type funct field
    always_comb begin
        w_alu_ctrl = CTRL_BAD;
        case (alu_op)
            2'b00:   w_alu_ctrl = CTRL_ADD;
            2'b01:   w_alu_ctrl = CTRL_SUB;
            2'b11:   w_alu_ctrl = CTRL_OR;
            2'b10: begin
                case (funct)
                    6'b100000: w_alu_ctrl = CTRL_ADD;
                    6'b100010: w_alu_ctrl = CTRL_SUB;
                    6'b100100: w_alu_ctrl = CTRL_AND;
                    6'b100101: w_alu_ctrl = CTRL_OR;
                    6'b100110: w_alu_ctrl = CTRL_XOR;
                    6'b100111: w_alu_ctrl = CTRL_NOR;
                    6'b101010: w_alu_ctrl = CTRL_SLT;
                    default:   w_alu_ctrl = CTRL_BAD;
                endcase
            end
            default: w_alu_ctrl = CTRL_BAD;
        endcase
    end

    assign alu_ctrl = w_alu_ctrl;
    assign w_sum    = a + b;
    assign w_diff   = a - b;
    assign w_jext   = {{(WIDTH-JIDX_W){jidx[JIDX_W-1]}}, jidx};

    // ALU datapath; add/sub wrap and discard carry
    always_comb begin
        w_alu_res = {WIDTH{1'b0}};
        case (w_alu_ctrl)
            CTRL_ADD: w_alu_res = w_sum;
            CTRL_SUB: w_alu_res = w_diff;
            CTRL_AND: w_alu_res = a & b;
            CTRL_OR:  w_alu_res = a | b;
            CTRL_XOR: w_alu_res = a ^ b;
            CTRL_NOR: w_alu_res = ~(a | b);
            CTRL_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default:  w_alu_res = {WIDTH{1'b0}};
        endcase
    end

`ifdef ALU_OVERFLOW_DETECT_EN
    // Signed overflow: sign of the wrapped result disagrees with what the operand signs imply
    always_comb begin
        w_ovf = 1'b0;
        case (w_alu_ctrl)
            CTRL_ADD: w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            CTRL_SUB: w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            default:  w_ovf = 1'b0;
        endcase
    end
`else
    assign w_ovf = 1'b0;
`endif

    // Output registers: reset wins over in_valid; idle cycles hold data and drop out_valid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result    <= {WIDTH{1'b0}};
            r_zero      <= 1'b1;
            r_jext      <= {WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (in_valid) begin
            r_result    <= w_alu_res;
            r_zero      <= (w_alu_res == {WIDTH{1'b0}});
            r_jext      <= w_jext;
            r_out_valid <= 1'b1;
            r_overflow  <= w_ovf;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign result    = r_result;
    assign zero      = r_zero;
    assign jext      = r_jext;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized traffic against a behavioural model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] a, b;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [25:0] jidx;
    logic [3:0]  alu_ctrl;
    logic [31:0] result, jext;
    logic        zero, out_valid, overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_result;
    logic        m_zero;
    logic [31:0] m_jext;
    logic        m_valid;
    logic        m_ovf;

`ifdef ALU_OVERFLOW_DETECT_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
        .alu_op(alu_op), .funct(funct), .jidx(jidx), .alu_ctrl(alu_ctrl),
        .result(result), .zero(zero), .jext(jext), .out_valid(out_valid),
        .overflow(overflow)
    );

    function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0001;
        case (f)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h26:   return 4'b1101;
            6'h27:   return 4'b1100;
            6'h2A:   return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    // Result and overflow from signed 64-bit arithmetic, truncated to 32 bits
    task automatic ref_calc(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                            output logic [31:0] res, output logic ovf);
        longint sx, sy, s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        s = 0;
        ovf = 1'b0;
        case (c)
            4'b0010: s = sx + sy;
            4'b0110: s = sx - sy;
            4'b0000: s = longint'(x & y);
            4'b0001: s = longint'(x | y);
            4'b1101: s = longint'(x ^ y);
            4'b1100: s = longint'(~(x | y));
            4'b0111: s = (sx < sy) ? 64'sd1 : 64'sd0;
            default: s = 0;
        endcase
        res = s[31:0];
        if ((c == 4'b0010 || c == 4'b0110) && (s > 64'sd2147483647 || s < -64'sd2147483648))
            ovf = OVF_EN;
    endtask

    // Advance the model with the current inputs, then let the DUT take the same edge
    task automatic tick();
        logic [31:0] r;
        logic        o;
        if (reset) begin
            m_result = 32'd0; m_zero = 1'b1; m_jext = 32'd0; m_valid = 1'b0; m_ovf = 1'b0;
        end else if (in_valid) begin
            ref_calc(ref_ctrl(alu_op, funct), a, b, r, o);
            m_result = r; m_zero = (r == 32'd0); m_ovf = o; m_valid = 1'b1;
            m_jext = 32'($signed(jidx));
        end else begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] x, input logic [31:0] y, input logic [25:0] j);
        in_valid = v; alu_op = op; funct = f; a = x; b = y; jidx = j;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 2'b00, 6'h20, 32'd5, 32'd3, 26'h3FFFFFF);
        tick();
        n_checks++;
        if ({result, zero, out_valid, jext, overflow} !== {32'd0, 1'b1, 1'b0, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: result=%h zero=%b valid=%b jext=%h ovf=%b, required 0/1/0/0/0",
                     result, zero, out_valid, jext, overflow);
        end
        reset = 1'b0;
    endtask

    task automatic test_add_overflow();
        drive(1'b1, 2'b10, 6'h20, 32'h7FFFFFFF, 32'd1, 26'd0);
        n_checks++;
        if (alu_ctrl !== 4'b0010) begin
            n_fail++; $display("FAIL add_ctrl: got %b, required 0010", alu_ctrl);
        end
        tick();
        n_checks++;
        if ({result, zero, out_valid, overflow} !== {32'h80000000, 1'b0, 1'b1, OVF_EN}) begin
            n_fail++;
            $display("FAIL add_ovf: result=%h zero=%b valid=%b ovf=%b, required 80000000/0/1/%b",
                     result, zero, out_valid, overflow, OVF_EN);
        end
    endtask

    task automatic test_beq();
        drive(1'b1, 2'b01, 6'h00, 32'h1234, 32'h1234, 26'd0);
        n_checks++;
        if (alu_ctrl !== 4'b0110) begin
            n_fail++; $display("FAIL beq_ctrl: got %b, required 0110", alu_ctrl);
        end
        tick();
        n_checks++;
        if ({result, zero, overflow} !== {32'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL beq: result=%h zero=%b ovf=%b, required 0/1/0", result, zero, overflow);
        end
    endtask

    task automatic test_slt();
        drive(1'b1, 2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1, 26'd0);
        tick();
        n_checks++;
        if ({result, zero} !== {32'd1, 1'b0}) begin
            n_fail++; $display("FAIL slt_neg: result=%h zero=%b, required 1/0", result, zero);
        end
        drive(1'b1, 2'b10, 6'h2A, 32'd1, 32'hFFFFFFFF, 26'd0);
        tick();
        n_checks++;
        if ({result, zero} !== {32'd0, 1'b1}) begin
            n_fail++; $display("FAIL slt_pos: result=%h zero=%b, required 0/1", result, zero);
        end
    endtask

    task automatic test_jext();
        drive(1'b1, 2'b00, 6'h00, 32'd5, 32'd3, 26'h2000000);
        tick();
        n_checks++;
        if (jext !== 32'hFE000000) begin
            n_fail++; $display("FAIL jext_neg: got %h, required fe000000", jext);
        end
        n_checks++;
        if (result !== 32'd8) begin
            n_fail++; $display("FAIL lw_add: got %h, required 00000008", result);
        end
        drive(1'b1, 2'b00, 6'h00, 32'd5, 32'd3, 26'h0000010);
        tick();
        n_checks++;
        if (jext !== 32'h00000010) begin
            n_fail++; $display("FAIL jext_pos: got %h, required 00000010", jext);
        end
    endtask

    task automatic test_invalid_funct();
        drive(1'b1, 2'b10, 6'b000011, 32'hDEADBEEF, 32'h12345678, 26'd0);
        n_checks++;
        if (alu_ctrl !== 4'b1111) begin
            n_fail++; $display("FAIL bad_ctrl: got %b, required 1111", alu_ctrl);
        end
        tick();
        n_checks++;
        if ({result, zero, overflow} !== {32'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL bad_result: result=%h zero=%b ovf=%b, required 0/1/0", result, zero, overflow);
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 2'b10, 6'h25, 32'h00F0, 32'h0F00, 26'h155);
        tick();
        drive(1'b0, 2'b10, 6'h22, 32'h1, 32'h9, 26'h3FFFFFF);
        tick();
        n_checks++;
        if ({result, zero, jext, out_valid} !== {32'h0FF0, 1'b0, 32'h155, 1'b0}) begin
            n_fail++;
            $display("FAIL hold: result=%h zero=%b jext=%h valid=%b, required 00000ff0/0/00000155/0",
                     result, zero, jext, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 2'b10, 6'h20 + 6'($urandom_range(0, 10)), $urandom, $urandom, 26'($urandom));
            tick();
            n_checks++;
            if ({out_valid, overflow, zero, result, jext} !== {m_valid, m_ovf, m_zero, m_result, m_jext}) begin
                n_fail++;
                $display("FAIL b2b[%0d]: v/o/z/res/jext=%b%b%b %h %h, required %b%b%b %h %h", i,
                         out_valid, overflow, zero, result, jext, m_valid, m_ovf, m_zero, m_result, m_jext);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0]  fl [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00};
        logic [31:0] x, y;
        logic [5:0]  f;
        for (int i = 0; i < 300; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 7)];
            x = $urandom;
            y = ($urandom_range(0, 4) == 0) ? x : 32'($urandom);
            drive(($urandom_range(0, 3) != 0), 2'($urandom), f, x, y, 26'($urandom));
            n_checks++;
            if (alu_ctrl !== ref_ctrl(alu_op, funct)) begin
                n_fail++;
                $display("FAIL rnd_ctrl[%0d]: op=%b funct=%b got %b, required %b", i, alu_op, funct,
                         alu_ctrl, ref_ctrl(alu_op, funct));
            end
            tick();
            n_checks++;
            if ({out_valid, overflow, zero, result, jext} !== {m_valid, m_ovf, m_zero, m_result, m_jext}) begin
                n_fail++;
                $display("FAIL rnd[%0d]: v/o/z/res/jext=%b%b%b %h %h, required %b%b%b %h %h", i,
                         out_valid, overflow, zero, result, jext, m_valid, m_ovf, m_zero, m_result, m_jext);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0;
        alu_op = 2'b00; funct = 6'd0; jidx = 26'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_add_overflow();
        test_beq();
        test_slt();
        test_jext();
        test_invalid_funct();
        test_hold();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
